// File: rtl/mult_unit.sv
// Sequential radix-2 multiplier: one partial-product step per cycle, signed by default.
// MULT_UNIT_UNSIGNED_EN adds an is_unsigned input selecting an unsigned product.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULT_UNIT_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FIN  = CW'(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   m;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mq;
  logic             uns;
  logic             uns_in;
  logic [WIDTH+1:0] addend;
  logic [WIDTH+1:0] sum;

`ifdef MULT_UNIT_UNSIGNED_EN
  assign uns_in = is_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == FIN) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The multiplier's sign bit carries weight -2^(W-1): subtract on the last step.
  always_comb begin
    addend = '0;
    if (mq[0]) begin
      if (cnt == LAST && !uns) addend = -{m[WIDTH], m};
      else                     addend = {m[WIDTH], m};
    end
    sum = {acc[WIDTH], acc} + addend;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      m     <= '0;
      acc   <= '0;
      mq    <= '0;
      uns   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        m   <= {!uns_in & a[WIDTH-1], a};
        mq  <= b;
        acc <= '0;
        cnt <= '0;
        uns <= uns_in;
      end else if (state == RUN) begin
        if (cnt != FIN) begin
          acc <= sum[WIDTH+1:1];
          mq  <= {sum[0], mq[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end else begin
          hi <= acc[WIDTH-1:0];
          lo <= mq;
        end
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
